// File: rtl/decode_issue_ctrl_if.sv
// decode_issue_ctrl_if
//   Bundles the decode-side handshake and operand fields, the EXE-side
//   handshake and the registered output fields, and the serialization
//   status signals (sys_pulse, freeze, busy) of decode_issue_ctrl.
//   modport slave  : the view used by decode_issue_ctrl itself.
//   modport master : the view used by whatever drives decode and consumes EXE.
interface decode_issue_ctrl_if #(
    parameter int WIDTH       = 32,
    parameter int REG_BITS    = 5,
    parameter int ALUCTL_BITS = 6
);
    // decode side
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_instr;
    logic [WIDTH-1:0]       in_pc;
    logic [WIDTH-1:0]       in_opa;
    logic [WIDTH-1:0]       in_opb;
    logic [REG_BITS-1:0]    in_dest;
    logic                   in_regwrite;
    logic [ALUCTL_BITS-1:0] in_aluctl;
    logic                   in_memread;
    logic                   in_memwrite;
    logic                   in_serialize;
    logic                   in_notify;
    logic                   flush;
    // EXE side
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_instr;
    logic [WIDTH-1:0]       out_pc;
    logic [WIDTH-1:0]       out_opa;
    logic [WIDTH-1:0]       out_opb;
    logic [REG_BITS-1:0]    out_dest;
    logic                   out_regwrite;
    logic [ALUCTL_BITS-1:0] out_aluctl;
    logic                   out_memread;
    logic                   out_memwrite;
    // serialization status
    logic                   sys_pulse;
    logic                   freeze;
    logic                   busy;

    modport slave (
        input  in_valid, in_instr, in_pc, in_opa, in_opb, in_dest, in_regwrite,
               in_aluctl, in_memread, in_memwrite, in_serialize, in_notify,
               flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_opa, out_opb,
               out_dest, out_regwrite, out_aluctl, out_memread, out_memwrite,
               sys_pulse, freeze, busy
    );

    modport master (
        output in_valid, in_instr, in_pc, in_opa, in_opb, in_dest, in_regwrite,
               in_aluctl, in_memread, in_memwrite, in_serialize, in_notify,
               flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_opa, out_opb,
               out_dest, out_regwrite, out_aluctl, out_memread, out_memwrite,
               sys_pulse, freeze, busy
    );
endinterface

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl
//   One-entry decode->EXE pipeline register with a serialization controller.
//   Ordinary ops pass through with one cycle of latency. A serializing op
//   (syscall/LL/SC) is issued with its side effects stripped, then the front
//   end is frozen for DRAIN_CYCLES cycles after the op has left, a one-cycle
//   sys_pulse tells the simulator (if requested), and one recovery cycle
//   follows before new ops are accepted.
//   Ports:
//     CLK   - rising-edge clock
//     RESET - asynchronous, active-high reset
//     bus   - decode_issue_ctrl_if.slave: in_* handshake/fields, flush,
//             out_* handshake/fields, sys_pulse, freeze, busy
module decode_issue_ctrl #(
    parameter int WIDTH        = 32,
    parameter int REG_BITS     = 5,
    parameter int ALUCTL_BITS  = 6,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    decode_issue_ctrl_if.slave bus
);

    generate
        if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
            $error("decode_issue_ctrl: DRAIN_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        NOTIFY  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0]       instr;
        logic [WIDTH-1:0]       pc;
        logic [WIDTH-1:0]       opa;
        logic [WIDTH-1:0]       opb;
        logic [REG_BITS-1:0]    dest;
        logic                   regwrite;
        logic [ALUCTL_BITS-1:0] aluctl;
        logic                   memread;
        logic                   memwrite;
    } out_t;

    state_t     state_q,     state_d;
    logic [3:0] cnt_q,       cnt_d;
    logic       notify_q,    notify_d;
    logic       out_valid_q, out_valid_d;
    logic       sys_pulse_q, sys_pulse_d;
    out_t       out_q,       out_d;

    logic in_ready;
    logic accept;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        notify_d    = notify_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        sys_pulse_d = 1'b0;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // A flushed accept is dropped entirely: no load and no serialization.
        if (accept && !bus.flush) begin
            out_valid_d    = 1'b1;
            out_d.instr    = bus.in_instr;
            out_d.pc       = bus.in_pc;
            out_d.aluctl   = bus.in_aluctl;
            if (bus.in_serialize) begin
                out_d.opa      = '0;
                out_d.opb      = '0;
                out_d.dest     = '0;
                out_d.regwrite = 1'b0;
                out_d.memread  = 1'b0;
                out_d.memwrite = 1'b0;
                notify_d       = bus.in_notify;
                cnt_d          = DRAIN_INIT;
                state_d        = DRAIN;
            end else begin
                out_d.opa      = bus.in_opa;
                out_d.opb      = bus.in_opb;
                out_d.dest     = bus.in_dest;
                out_d.regwrite = bus.in_regwrite && (bus.in_dest != '0);
                out_d.memread  = bus.in_memread;
                out_d.memwrite = bus.in_memwrite;
            end
        end

        if (bus.flush) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            DRAIN: begin
                // Count only once the serializing op is gone from the output
                // register (consumed or flushed at this edge).
                if (!out_valid_d) begin
                    if (cnt_q <= 4'd1) begin
                        cnt_d       = 4'd0;
                        state_d     = NOTIFY;
                        sys_pulse_d = notify_q;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            NOTIFY: begin
                notify_d = 1'b0;
                state_d  = RECOVER;
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            notify_q    <= 1'b0;
            out_valid_q <= 1'b0;
            sys_pulse_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            notify_q    <= notify_d;
            out_valid_q <= out_valid_d;
            sys_pulse_q <= sys_pulse_d;
            out_q       <= out_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_instr    = out_q.instr;
    assign bus.out_pc       = out_q.pc;
    assign bus.out_opa      = out_q.opa;
    assign bus.out_opb      = out_q.opb;
    assign bus.out_dest     = out_q.dest;
    assign bus.out_regwrite = out_q.regwrite;
    assign bus.out_aluctl   = out_q.aluctl;
    assign bus.out_memread  = out_q.memread;
    assign bus.out_memwrite = out_q.memwrite;
    assign bus.sys_pulse    = sys_pulse_q;
    assign bus.freeze       = (state_q == DRAIN);
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Testbench for decode_issue_ctrl (DRAIN_CYCLES=3): a vector table for the
// plain pipeline behaviour, plus hand-written serialization and reset runs.
module tb_decode_issue_ctrl;

    logic CLK;
    logic RESET;
    int   total = 0;
    int   bad   = 0;

    decode_issue_ctrl_if #(.WIDTH(32), .REG_BITS(5), .ALUCTL_BITS(6)) bus();

    decode_issue_ctrl #(
        .WIDTH(32), .REG_BITS(5), .ALUCTL_BITS(6), .DRAIN_CYCLES(3)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic        rw;
        logic [5:0]  alu;
        logic        mr;
        logic        mw;
        logic        fl;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [4:0]  e_dest;
        logic        e_rw;
        logic [5:0]  e_alu;
        logic        e_mr;
        logic        e_mw;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(
        input logic iv, input logic [31:0] instr, input logic [31:0] pc,
        input logic [4:0] dest, input logic rw, input logic [5:0] alu,
        input logic mr, input logic mw, input logic fl, input logic ordy,
        input logic e_rdy, input logic e_ov, input logic [31:0] e_instr,
        input logic [31:0] e_pc, input logic [4:0] e_dest, input logic e_rw,
        input logic [5:0] e_alu, input logic e_mr, input logic e_mw);
        vec_t v;
        v.iv = iv; v.instr = instr; v.pc = pc; v.dest = dest; v.rw = rw;
        v.alu = alu; v.mr = mr; v.mw = mw; v.fl = fl; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_instr = e_instr; v.e_pc = e_pc;
        v.e_dest = e_dest; v.e_rw = e_rw; v.e_alu = e_alu; v.e_mr = e_mr;
        v.e_mw = e_mw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Operand stimulus is tied to instr/pc so expected operands follow from
    // the expected instr/pc.
    task automatic drive_op(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [4:0] dest, input logic rw, input logic [5:0] alu,
                            input logic mr, input logic mw, input logic ser, input logic ntf);
        bus.in_valid     = iv;
        bus.in_instr     = instr;
        bus.in_pc        = pc;
        bus.in_opa       = ~instr;
        bus.in_opb       = instr ^ pc;
        bus.in_dest      = dest;
        bus.in_regwrite  = rw;
        bus.in_aluctl    = alu;
        bus.in_memread   = mr;
        bus.in_memwrite  = mw;
        bus.in_serialize = ser;
        bus.in_notify    = ntf;
    endtask

    task automatic chk_status(input string tag, input logic fz, input logic sp,
                              input logic bz, input logic rdy, input logic ov);
        chk($sformatf("%s freeze", tag), 32'(bus.freeze), 32'(fz));
        chk($sformatf("%s sys_pulse", tag), 32'(bus.sys_pulse), 32'(sp));
        chk($sformatf("%s busy", tag), 32'(bus.busy), 32'(bz));
        chk($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'(rdy));
        chk($sformatf("%s out_valid", tag), 32'(bus.out_valid), 32'(ov));
    endtask

    // Accept a serializing op, then check cycles t1..tn against per-cycle
    // bit masks (bit k = expectation at tk; ordy_m bit k = out_ready driven in tk).
    task automatic ser_run(input string tag, input logic [31:0] instr, input logic ntf,
                           input int n, input logic [15:0] ordy_m, input logic [15:0] fz_m,
                           input logic [15:0] sp_m, input logic [15:0] busy_m,
                           input logic [15:0] rdy_m, input logic [15:0] ov_m, input logic b2b);
        drive_op(1'b1, instr, 32'h200, 5'd2, 1'b1, 6'h3F, 1'b1, 1'b1, 1'b1, ntf);
        bus.out_ready = 1'b1;
        #1;
        chk($sformatf("%s t0 in_ready", tag), 32'(bus.in_ready), 32'd1);
        tick();
        for (int k = 1; k <= n; k++) begin
            chk_status($sformatf("%s t%0d", tag, k), fz_m[k], sp_m[k], busy_m[k], rdy_m[k], ov_m[k]);
            if (k == 1) begin
                chk($sformatf("%s instr", tag), bus.out_instr, instr);
                chk($sformatf("%s pc", tag), bus.out_pc, 32'h200);
                chk($sformatf("%s aluctl", tag), 32'(bus.out_aluctl), 32'h3F);
                chk($sformatf("%s regwrite", tag), 32'(bus.out_regwrite), 32'd0);
                chk($sformatf("%s memread", tag), 32'(bus.out_memread), 32'd0);
                chk($sformatf("%s memwrite", tag), 32'(bus.out_memwrite), 32'd0);
                chk($sformatf("%s opa", tag), bus.out_opa, 32'd0);
                chk($sformatf("%s opb", tag), bus.out_opb, 32'd0);
                chk($sformatf("%s dest", tag), 32'(bus.out_dest), 32'd0);
            end
            if (k < n) begin
                if (b2b)
                    drive_op(1'b1, 32'h0000000D, 32'h200, 5'd2, 1'b1, 6'h3F, 1'b1, 1'b1, 1'b1, 1'b0);
                else
                    bus.in_valid = 1'b0;
                bus.out_ready = ordy_m[k];
                tick();
            end
        end
    endtask

    initial begin
        RESET = 1'b1;
        drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("reset out_instr", bus.out_instr, 32'd0);
        chk("reset out_aluctl", 32'(bus.out_aluctl), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        tick();

        // ---- table-driven pipeline vectors ----
        //              iv  instr         pc      dst  rw alu   mr mw fl or | rdy ov e_instr      e_pc    e_dst e_rw e_alu e_mr e_mw
        vecs[0]  = mk(1, 32'h11,       32'h100, 5'd3,  1, 6'h05, 0, 0, 0, 1,  1, 1, 32'h11, 32'h100, 5'd3,  1, 6'h05, 0, 0);
        vecs[1]  = mk(1, 32'h22,       32'h104, 5'd0,  1, 6'h06, 1, 0, 0, 1,  1, 1, 32'h22, 32'h104, 5'd0,  0, 6'h06, 1, 0);
        vecs[2]  = mk(1, 32'h33,       32'h108, 5'd7,  0, 6'h07, 0, 1, 0, 1,  1, 1, 32'h33, 32'h108, 5'd7,  0, 6'h07, 0, 1);
        vecs[3]  = mk(1, 32'h44,       32'h10C, 5'd31, 1, 6'h3F, 0, 0, 0, 1,  1, 1, 32'h44, 32'h10C, 5'd31, 1, 6'h3F, 0, 0);
        vecs[4]  = mk(0, 32'h0,        32'h0,   5'd0,  0, 6'h00, 0, 0, 0, 1,  1, 0, 32'h0,  32'h0,   5'd0,  0, 6'h00, 0, 0);
        vecs[5]  = mk(1, 32'h55,       32'h110, 5'd4,  1, 6'h01, 0, 0, 0, 0,  1, 1, 32'h55, 32'h110, 5'd4,  1, 6'h01, 0, 0);
        vecs[6]  = mk(1, 32'h66,       32'h114, 5'd5,  1, 6'h02, 0, 0, 0, 0,  0, 1, 32'h55, 32'h110, 5'd4,  1, 6'h01, 0, 0);
        vecs[7]  = mk(1, 32'h66,       32'h114, 5'd5,  1, 6'h02, 0, 0, 0, 0,  0, 1, 32'h55, 32'h110, 5'd4,  1, 6'h01, 0, 0);
        vecs[8]  = mk(1, 32'h66,       32'h114, 5'd5,  1, 6'h02, 0, 0, 0, 1,  1, 1, 32'h66, 32'h114, 5'd5,  1, 6'h02, 0, 0);
        vecs[9]  = mk(1, 32'h01234567, 32'h118, 5'd6,  1, 6'h08, 0, 0, 1, 1,  1, 0, 32'h0,  32'h0,   5'd0,  0, 6'h00, 0, 0);
        vecs[10] = mk(0, 32'h0,        32'h0,   5'd0,  0, 6'h00, 0, 0, 0, 1,  1, 0, 32'h0,  32'h0,   5'd0,  0, 6'h00, 0, 0);
        vecs[11] = mk(0, 32'h0,        32'h0,   5'd0,  0, 6'h00, 0, 0, 0, 1,  1, 0, 32'h0,  32'h0,   5'd0,  0, 6'h00, 0, 0);

        for (int i = 0; i < 12; i++) begin
            drive_op(vecs[i].iv, vecs[i].instr, vecs[i].pc, vecs[i].dest, vecs[i].rw,
                     vecs[i].alu, vecs[i].mr, vecs[i].mw, 1'b0, 1'b0);
            bus.flush     = vecs[i].fl;
            bus.out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
            tick();
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'd0);
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d instr", i), bus.out_instr, vecs[i].e_instr);
                chk($sformatf("vec%0d pc", i), bus.out_pc, vecs[i].e_pc);
                chk($sformatf("vec%0d opa", i), bus.out_opa, ~vecs[i].e_instr);
                chk($sformatf("vec%0d opb", i), bus.out_opb, vecs[i].e_instr ^ vecs[i].e_pc);
                chk($sformatf("vec%0d dest", i), 32'(bus.out_dest), 32'(vecs[i].e_dest));
                chk($sformatf("vec%0d regwrite", i), 32'(bus.out_regwrite), 32'(vecs[i].e_rw));
                chk($sformatf("vec%0d aluctl", i), 32'(bus.out_aluctl), 32'(vecs[i].e_alu));
                chk($sformatf("vec%0d memread", i), 32'(bus.out_memread), 32'(vecs[i].e_mr));
                chk($sformatf("vec%0d memwrite", i), 32'(bus.out_memwrite), 32'(vecs[i].e_mw));
            end
            $display("vec%0d instr=%0h out_valid=%0b out_instr=%0h", i, vecs[i].instr,
                     bus.out_valid, bus.out_instr);
        end
        bus.flush = 1'b0;

        // ---- syscall, ready throughout, with an LL waiting behind it ----
        ser_run("sys", 32'h0000000C, 1'b1, 6, 16'hFFFF, 16'h000E, 16'h0010, 16'h003E,
                16'h0040, 16'h0002, 1'b1);
        $display("syscall run done busy=%0b", bus.busy);
        // ---- the waiting LL now runs as a fresh serialization, no pulse ----
        ser_run("ll", 32'h0000000D, 1'b0, 6, 16'hFFFF, 16'h000E, 16'h0000, 16'h003E,
                16'h0040, 16'h0002, 1'b0);
        $display("ll run done busy=%0b", bus.busy);
        // ---- syscall with EXE stalled on t1..t2 ----
        ser_run("stall", 32'h0000000C, 1'b1, 8, 16'hFFF9, 16'h003E, 16'h0040, 16'h00FE,
                16'h0100, 16'h000E, 1'b0);
        $display("stalled syscall run done busy=%0b", bus.busy);

        // ---- reset in the middle of a drain ----
        drive_op(1'b1, 32'h0000000C, 32'h300, 5'd2, 1'b1, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b1);
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("rst pre freeze", 32'(bus.freeze), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        chk_status("rst async", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst async instr", bus.out_instr, 32'd0);
        chk("rst async pc", bus.out_pc, 32'd0);
        chk("rst async aluctl", 32'(bus.out_aluctl), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        drive_op(1'b1, 32'h77, 32'h400, 5'd1, 1'b1, 6'h09, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst post in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("rst post out_valid", 32'(bus.out_valid), 32'd1);
        chk("rst post instr", bus.out_instr, 32'h77);
        chk("rst post regwrite", 32'(bus.out_regwrite), 32'd1);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_status($sformatf("rst after%0d", k), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        $display("reset run done busy=%0b", bus.busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
